pipe_hazard_ctrl: RTL and testbench

- Parametrised successor to the split forwarding and hazard-detection logic of the 5-stage pipeline. One block owns EX forwarding selects, load-use and branch-operand stalls, taken-branch IF/ID flush, and multi-cycle data-memory freeze.
- Adds a configurable memory-latency freeze FSM and a saturating stall-cycle counter; register-address width is generic.
- Sits beside the four pipeline registers and drives their write-enable, bubble and flush controls, plus PC write-enable.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_mem_freeze_fsm.sv | 89 ++++++++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline hazard controller:
//             forwarding-select codes, freeze FSM state encoding and the
//             register-address match helper.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // Memory freeze FSM states
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } frz_state_t;

    // Register 0 is hard-wired, so it never produces a dependency.
    // Callers zero-extend their addresses to 32 bits.
    function automatic logic addr_match(input logic [31:0] a, input logic [31:0] b);
        return (a != 32'd0) && (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mem_freeze_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mem_freeze_fsm
//  Purpose  : Holds the back end of the pipeline for MEM_LAT-1 cycles for
//             every load/store that reaches MEM.
//  Ports    : clk_i    - clock
//             rst_i    - asynchronous active-low reset
//             memop_i  - EX/MEM holds a load or store
//             freeze_o - pipeline freeze request (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_freeze_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic memop_i,
    output logic freeze_o
);

    localparam int   c_CW         = $clog2(MEM_LAT) + 1;
    localparam int   c_CNT_INIT   = (MEM_LAT > 2) ? (MEM_LAT - 2) : 0;
    localparam logic c_CAN_FREEZE = (MEM_LAT > 1);

    frz_state_t      r_state;
    frz_state_t      w_state_nxt;
    logic            r_served;
    logic            w_served_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_freeze;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_RUN;
            r_served <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_served <= w_served_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // The RUN cycle that detects the op is the first frozen cycle; WAIT
    // covers the remaining MEM_LAT-2. The served flag stops the same op from
    // re-triggering on the cycle it finally advances.
    always_comb begin
        w_state_nxt  = r_state;
        w_served_nxt = r_served;
        w_cnt_nxt    = r_cnt;
        w_freeze     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (memop_i && !r_served && c_CAN_FREEZE) begin
                    w_freeze = 1'b1;
                    if (MEM_LAT > 2) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_CW'(c_CNT_INIT);
                    end else begin
                        w_served_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_freeze  = 1'b1;
                w_cnt_nxt = r_cnt - c_CW'(1);
                if (r_cnt <= c_CW'(1)) begin
                    w_state_nxt  = ST_RUN;
                    w_served_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (!w_freeze) begin
            w_served_nxt = 1'b0;
        end
    end

    // Reset aborts a freeze immediately, even with memop still asserted.
    assign freeze_o = rst_i & w_freeze;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Forwarding selects, load-use / branch-operand stalls, taken
//             branch flush and memory-latency freeze for a 5-stage pipeline,
//             plus a saturating stall-cycle counter.
//  Ports    : id_*      - ID-stage operand addresses and branch info
//             ex_*      - ID/EX operand addresses and EX destination/control
//             mem_*     - EX/MEM destination and control
//             wb_*      - MEM/WB destination and RegWrite
//             fwd_a/b_o - ALU operand selects (REG / WB / MEM)
//             pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
//             hold_exmem_o - pipeline register controls
//             stall_cycles_o - saturating stalled/frozen cycle count
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rt_i,
    input  logic              id_branch_i,
    input  logic              branch_taken_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    input  logic              mem_memop_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    input  logic              perf_clr_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              hold_exmem_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    logic             w_freeze;
    logic             w_ls;
    logic             w_bs;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_cnt;

    mem_freeze_fsm #(
        .MEM_LAT (MEM_LAT)
    ) u_freeze (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .memop_i  (mem_memop_i),
        .freeze_o (w_freeze)
    );

    // EX forwarding; MEM holds the younger result so it wins over WB.
    always_comb begin
        fwd_a_o = FWD_REG;
        fwd_b_o = FWD_REG;
        if (mem_regwrite_i && addr_match(32'(mem_rd_i), 32'(ex_rs_i))) begin
            fwd_a_o = FWD_MEM;
        end else if (wb_regwrite_i && addr_match(32'(wb_rd_i), 32'(ex_rs_i))) begin
            fwd_a_o = FWD_WB;
        end
        if (mem_regwrite_i && addr_match(32'(mem_rd_i), 32'(ex_rt_i))) begin
            fwd_b_o = FWD_MEM;
        end else if (wb_regwrite_i && addr_match(32'(wb_rd_i), 32'(ex_rt_i))) begin
            fwd_b_o = FWD_WB;
        end
    end

    // Load-use: the loaded value is not available to EX forwarding in time.
    assign w_ls = ex_memread_i &&
                  (addr_match(32'(ex_rd_i), 32'(id_rs_i)) ||
                   (id_use_rt_i && addr_match(32'(ex_rd_i), 32'(id_rt_i))));

    // Branches compare in ID, so any in-flight ALU result in EX or a load in
    // MEM is too late. Branches always read both rs and rt.
    assign w_bs = id_branch_i &&
                  ((ex_regwrite_i &&
                    (addr_match(32'(ex_rd_i), 32'(id_rs_i)) ||
                     addr_match(32'(ex_rd_i), 32'(id_rt_i)))) ||
                   (mem_memread_i &&
                    (addr_match(32'(mem_rd_i), 32'(id_rs_i)) ||
                     addr_match(32'(mem_rd_i), 32'(id_rt_i)))));

    assign w_stall = w_ls | w_bs;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        hold_exmem_o  = 1'b0;
        if (w_freeze) begin
            // ID/EX holds too: its register sees !ifid_write_o together with hold.
            hold_exmem_o = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (w_stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (id_branch_i && branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (perf_clr_i) begin
            r_stall_cnt <= '0;
        end else if ((w_freeze || w_stall) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench; two instances (MEM_LAT=4 and MEM_LAT=1,
//             both with a 4-bit stall counter) compared against a
//             behavioural model of the hazard rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_use_rt, id_branch, taken;
    logic          ex_regwrite, ex_memread;
    logic          mem_regwrite, mem_memread, mem_memop;
    logic          wb_regwrite, perf_clr;

    logic [1:0]    fwd_a [2];
    logic [1:0]    fwd_b [2];
    logic          pcw [2];
    logic          ifidw [2];
    logic          flush [2];
    logic          bubble [2];
    logic          hold [2];
    logic [CW-1:0] scnt [2];

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(4), .CNT_W(CW)) u_dut_lat4 (
        .clk_i(clk), .rst_i(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
        .id_branch_i(id_branch), .branch_taken_i(taken),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
        .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .mem_memread_i(mem_memread), .mem_memop_i(mem_memop),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .perf_clr_i(perf_clr),
        .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]), .pc_write_o(pcw[0]),
        .ifid_write_o(ifidw[0]), .ifid_flush_o(flush[0]),
        .idex_bubble_o(bubble[0]), .hold_exmem_o(hold[0]),
        .stall_cycles_o(scnt[0])
    );

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(1), .CNT_W(CW)) u_dut_lat1 (
        .clk_i(clk), .rst_i(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
        .id_branch_i(id_branch), .branch_taken_i(taken),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
        .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .mem_memread_i(mem_memread), .mem_memop_i(mem_memop),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .perf_clr_i(perf_clr),
        .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]), .pc_write_o(pcw[1]),
        .ifid_write_o(ifidw[1]), .ifid_flush_o(flush[1]),
        .idex_bubble_o(bubble[1]), .hold_exmem_o(hold[1]),
        .stall_cycles_o(scnt[1])
    );

    // ------------------------------------------------------------------
    // Reference model: each memory op in MEM is frozen for LAT-1 cycles
    // counted since the pipeline last advanced.
    // ------------------------------------------------------------------
    int            n_vec = 0;
    int            n_bad = 0;
    int            lat [2] = '{4, 1};
    int            frz_run [2] = '{0, 0};
    int            cnt_m [2] = '{0, 0};
    logic          exp_frz [2];
    logic          exp_stl;

    function automatic logic dep(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_of(input logic [AW-1:0] src);
        if (mem_regwrite && dep(mem_rd, src)) return 2'd2;
        if (wb_regwrite && dep(wb_rd, src))   return 2'd1;
        return 2'd0;
    endfunction

    task automatic check(input string tag, input int d, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        logic ls, bs, any;
        ls = ex_memread && (dep(ex_rd, id_rs) || (id_use_rt && dep(ex_rd, id_rt)));
        bs = id_branch && ((ex_regwrite && (dep(ex_rd, id_rs) || dep(ex_rd, id_rt))) ||
                           (mem_memread && (dep(mem_rd, id_rs) || dep(mem_rd, id_rt))));
        exp_stl = ls | bs;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                frz_run[d] = 0;
                cnt_m[d]   = 0;
            end
            exp_frz[d] = rst_n && mem_memop && (lat[d] > 1) && (frz_run[d] < lat[d] - 1);
            any = exp_frz[d] | exp_stl;
            check("fwd_a",  d, int'(fwd_a[d]),  int'(fwd_of(ex_rs)));
            check("fwd_b",  d, int'(fwd_b[d]),  int'(fwd_of(ex_rt)));
            check("pc_wr",  d, int'(pcw[d]),    int'(!any));
            check("ifid_wr",d, int'(ifidw[d]),  int'(!any));
            check("bubble", d, int'(bubble[d]), int'(!exp_frz[d] && exp_stl));
            check("flush",  d, int'(flush[d]),  int'(!any && id_branch && taken));
            check("hold",   d, int'(hold[d]),   int'(exp_frz[d]));
            check("stallcnt", d, int'(scnt[d]), cnt_m[d]);
        end
    endtask

    // Check at negedge+1, then advance the model across the next posedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                frz_run[d] = exp_frz[d] ? frz_run[d] + 1 : 0;
                if (perf_clr)                                  cnt_m[d] = 0;
                else if ((exp_frz[d] || exp_stl) && cnt_m[d] != (1 << CW) - 1) cnt_m[d]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0; id_use_rt = 1'b0; id_branch = 1'b0;
        taken = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_regwrite = 1'b0; mem_memread = 1'b0; mem_memop = 1'b0;
        wb_regwrite = 1'b0; perf_clr = 1'b0;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_pc_wr", 0, int'(pcw[0]), 1);
        check("rst_hold", 0, int'(hold[0]), 0);
        check("rst_cnt", 0, int'(scnt[0]), 0);
        step();
        rst_n = 1'b1;
        step();

        // Forwarding priority
        ex_rs = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1;
        #1 check("fwd_mem_prio", 0, int'(fwd_a[0]), 2);
        step();
        mem_regwrite = 1'b0;
        #1 check("fwd_wb", 0, int'(fwd_a[0]), 1);
        step();
        mem_rd = '0; wb_rd = '0; mem_regwrite = 1'b1;
        #1 check("fwd_reg_r0", 0, int'(fwd_a[0]), 0);
        step();
        clr_in();

        // Load-use on rt: one stall cycle
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
        #1 check("lu_bubble", 0, int'(bubble[0]), 1);
        step();
        clr_in();
        #1 check("lu_cnt", 0, int'(scnt[0]), 1);
        step();

        // Load feeding a branch: EX phase, MEM phase, then taken flush
        id_branch = 1'b1; taken = 1'b1; id_rs = 5'd9;
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
        step();
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = '0;
        mem_rd = 5'd9; mem_memread = 1'b1; mem_regwrite = 1'b1;
        #1 check("lb_stall2", 1, int'(bubble[1]), 1);
        step();
        mem_rd = '0; mem_memread = 1'b0; mem_regwrite = 1'b0;
        wb_rd = 5'd9; wb_regwrite = 1'b1;
        #1 check("lb_flush", 1, int'(flush[1]), 1);
        step();
        clr_in();
        step();

        // Two back-to-back memory ops: 3 + 3 frozen cycles on MEM_LAT=4
        mem_memop = 1'b1;
        for (int i = 0; i < 8; i++) step();
        mem_memop = 1'b0;
        step();

        // Reset on the second freeze cycle
        mem_memop = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_wait_hold", 0, int'(hold[0]), 0);
        check("rst_wait_cnt", 0, int'(scnt[0]), 0);
        step();
        mem_memop = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mem_memop = 1'b1;
        #1 check("post_rst_frz", 0, int'(hold[0]), 1);
        for (int i = 0; i < 4; i++) step();
        clr_in();

        // Saturation with a continuous load-use stall, then clear
        ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        for (int i = 0; i < 20; i++) step();
        #1 check("sat", 0, int'(scnt[0]), 15);
        clr_in();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        #1 check("clr", 0, int'(scnt[0]), 0);
        step();

        // Randomised traffic; a memory op stays in MEM for its whole freeze
        for (int i = 0; i < 400; i++) begin
            id_rs        = AW'($urandom_range(0, 3));
            id_rt        = AW'($urandom_range(0, 3));
            ex_rs        = AW'($urandom_range(0, 3));
            ex_rt        = AW'($urandom_range(0, 3));
            ex_rd        = AW'($urandom_range(0, 3));
            mem_rd       = AW'($urandom_range(0, 3));
            wb_rd        = AW'($urandom_range(0, 3));
            id_use_rt    = 1'($urandom);
            id_branch    = 1'($urandom);
            taken        = 1'($urandom);
            ex_regwrite  = 1'($urandom);
            ex_memread   = ($urandom_range(0, 3) == 0);
            mem_regwrite = 1'($urandom);
            mem_memread  = 1'($urandom);
            wb_regwrite  = 1'($urandom);
            perf_clr     = ($urandom_range(0, 31) == 0);
            if (frz_run[0] > 0 && frz_run[0] < lat[0] - 1) mem_memop = 1'b1;
            else                                           mem_memop = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
